// File: rtl/mem_access_stage_pkg.sv
// Shared widths, FSM encoding and latched-request layout for the memory-access stage.
package mem_access_stage_pkg;

  localparam int unsigned W_OPR = 32;
  localparam int unsigned W_REG = 5;

  typedef enum logic {
    MA_IDLE = 1'b0,
    MA_BUSY = 1'b1
  } ma_state_e;

  // One accepted operation, held stable on the memory port for the whole transaction.
  typedef struct packed {
    logic             we;
    logic [W_OPR-1:0] addr;
    logic [W_OPR-1:0] wdata;
    logic [W_REG-1:0] dst;
  } ma_req_t;

endpackage

// File: rtl/mem_req_timer.sv
// Watchdog counter for an outstanding memory request. Cleared when a request is
// accepted, counts every waiting cycle, and flags the final permitted cycle so the
// owner can abort on that edge unless an ack arrives in the same cycle.
module mem_req_timer
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned     CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  // Cycle counter: clear wins, saturates on the last permitted waiting cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Expired means this cycle is the TIMEOUT-th one spent waiting.
  always_comb begin
    o_expired = (r_cnt == LAST);
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: latches one load/store from execute, runs a req/ack
// transaction on the data-memory port while stalling upstream, and returns load
// data to writeback. A watchdog aborts a request the memory never acknowledges.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [W_OPR-1:0] addr_i,
  input  logic             write_i,
  input  logic [W_OPR-1:0] data_i,
  input  logic [W_REG-1:0] dst_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  output logic [W_OPR-1:0] dmem_addr_o,
  output logic [W_OPR-1:0] dmem_wdata_o,
  input  logic             dmem_ack_i,
  input  logic [W_OPR-1:0] dmem_rdata_i,
  output logic             wb_valid_o,
  output logic [W_REG-1:0] wb_dst_o,
  output logic [W_OPR-1:0] wb_data_o,
  output logic             err_o
);

  ma_state_e        r_state;
  ma_state_e        w_state_nxt;
  ma_req_t          r_req;
  logic             r_kill;
  logic             r_err;
  logic             r_ld_done;
  logic [W_OPR-1:0] r_ld_data;
  logic [W_REG-1:0] r_ld_dst;
  logic             r_wb_valid;
  logic [W_OPR-1:0] r_wb_data;
  logic [W_REG-1:0] r_wb_dst;

  logic w_busy;
  logic w_accept;
  logic w_ack;
  logic w_expired;
  logic w_abort;

  assign w_busy   = (r_state == MA_BUSY);
  assign w_accept = (r_state == MA_IDLE) && valid_i && !flush_i;
  assign w_ack    = w_busy && dmem_ack_i;
  // An ack on the last permitted cycle completes normally instead of aborting.
  assign w_abort  = w_busy && !dmem_ack_i && w_expired;

  mem_req_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk     (clk_i),
    .i_rst     (rst_i),
    .i_clr     (w_accept),
    .i_en      (w_busy),
    .o_expired (w_expired)
  );

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= MA_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: accept in IDLE, leave BUSY on ack or watchdog abort.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MA_IDLE: if (w_accept)           w_state_nxt = MA_BUSY;
      MA_BUSY: if (w_ack || w_abort)   w_state_nxt = MA_IDLE;
      default:                         w_state_nxt = MA_IDLE;
    endcase
  end

  // FSM outputs, decoded from registered state only.
  always_comb begin
    stall_o    = 1'b0;
    dmem_req_o = 1'b0;
    if (r_state == MA_BUSY) begin
      stall_o    = 1'b1;
      dmem_req_o = 1'b1;
    end
  end

  // Request latch: captures the operation on accept and holds it on the port.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_req <= '0;
    end else if (w_accept) begin
      r_req <= '{we: write_i, addr: addr_i, wdata: data_i, dst: dst_i};
    end
  end

  assign dmem_we_o    = r_req.we;
  assign dmem_addr_o  = r_req.addr;
  assign dmem_wdata_o = r_req.wdata;

  // Kill flag: a flush while BUSY suppresses the pending load writeback.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_kill <= 1'b0;
    end else if (w_accept) begin
      r_kill <= 1'b0;
    end else if (w_busy && flush_i) begin
      r_kill <= 1'b1;
    end
  end

  // Completion capture: rdata is only valid with ack, so it is held here for one
  // cycle and presented to writeback on the following edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ld_done <= 1'b0;
      r_ld_data <= '0;
      r_ld_dst  <= '0;
    end else begin
      r_ld_done <= w_ack && !r_req.we && !r_kill && !flush_i;
      if (w_ack) begin
        r_ld_data <= dmem_rdata_i;
        r_ld_dst  <= r_req.dst;
      end
    end
  end

  // Writeback register: one-cycle valid pulse, data and dst hold between pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wb_valid <= 1'b0;
      r_wb_data  <= '0;
      r_wb_dst   <= '0;
    end else begin
      r_wb_valid <= r_ld_done;
      if (r_ld_done) begin
        r_wb_data <= r_ld_data;
        r_wb_dst  <= r_ld_dst;
      end
    end
  end

  assign wb_valid_o = r_wb_valid;
  assign wb_data_o  = r_wb_data;
  assign wb_dst_o   = r_wb_dst;

  // Sticky timeout error, cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (w_abort) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;

endmodule
